// File: rtl/imem_access_arbiter.sv
// Instruction-memory port arbiter: round-robin between fetch (IF) and debug loader (DBG),
// address screening, one-cycle tagged response. Optional macro IMEM_DBG_WRITE_EN enables DBG writes.
module imem_access_arbiter #(
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    output logic                  if_err,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [31:0]           dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [31:0]           dbg_rdata,
    output logic                  dbg_err,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic {
        OwnIf  = 1'b0,
        OwnDbg = 1'b1
    } owner_t;

    owner_t      last_gnt_q;
    logic        rsp_valid_q;
    owner_t      rsp_owner_q;
    logic        rsp_err_q;
    logic        rsp_write_q;

    logic        if_win;
    logic        dbg_win;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic        misaligned;
    logic        out_of_range;
    logic        wr_blocked;
    logic        acc_err;
    logic        dbg_write;

    // IF wins unless DBG also requests and IF had the previous grant.
    always_comb begin
        if_win  = resetn && if_req && (!dbg_req || (last_gnt_q == OwnDbg));
        dbg_win = resetn && dbg_req && !if_win;
        any_gnt = if_win || dbg_win;
    end

    always_comb begin
        sel_addr     = if_win ? if_addr : dbg_addr;
        misaligned   = (sel_addr[1:0] != 2'b00);
        out_of_range = (sel_addr[31:DEPTH_LOG2+2] != '0);
        dbg_write    = dbg_win && dbg_we;
`ifdef IMEM_DBG_WRITE_EN
        wr_blocked   = 1'b0;
`else
        // Write port disabled: the write is granted and acked with an error, never reaches memory.
        wr_blocked   = dbg_write;
`endif
        acc_err      = any_gnt && (misaligned || out_of_range || wr_blocked);
    end

    always_comb begin
        if_gnt    = if_win;
        dbg_gnt   = dbg_win;
        mem_en    = any_gnt && !acc_err;
`ifdef IMEM_DBG_WRITE_EN
        mem_we    = dbg_write && !acc_err;
`else
        mem_we    = 1'b0;
`endif
        mem_addr  = sel_addr[DEPTH_LOG2+1:2];
        mem_wdata = dbg_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt_q  <= OwnDbg;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= OwnIf;
            rsp_err_q   <= 1'b0;
            rsp_write_q <= 1'b0;
        end else begin
            if (any_gnt) begin
                last_gnt_q <= if_win ? OwnIf : OwnDbg;
            end
            rsp_valid_q <= any_gnt;
            rsp_owner_q <= if_win ? OwnIf : OwnDbg;
            rsp_err_q   <= acc_err;
            rsp_write_q <= dbg_write;
        end
    end

    // Flush only squashes the IF response; a DBG response in the same cycle is untouched.
    always_comb begin
        if_rvalid  = rsp_valid_q && (rsp_owner_q == OwnIf) && !if_flush;
        if_err     = if_rvalid && rsp_err_q;
        if_rdata   = (if_rvalid && !rsp_err_q) ? mem_rdata : 32'h0;
        dbg_rvalid = rsp_valid_q && (rsp_owner_q == OwnDbg);
        dbg_err    = dbg_rvalid && rsp_err_q;
        dbg_rdata  = (dbg_rvalid && !rsp_err_q && !rsp_write_q) ? mem_rdata : 32'h0;
    end

`ifndef SYNTHESIS
    a_one_grant : assert property (@(posedge clk) disable iff (!resetn) !(if_gnt && dbg_gnt));
    a_we_has_en : assert property (@(posedge clk) disable iff (!resetn) mem_we |-> mem_en);
    a_one_rsp   : assert property (@(posedge clk) disable iff (!resetn) !(if_rvalid && dbg_rvalid));
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Scoreboard bench for imem_access_arbiter with a behavioural synchronous-read memory.
module tb_imem_access_arbiter;
    localparam int unsigned DL = 11;

    logic          clk = 1'b0;
    logic          resetn;
    logic          if_req, if_flush, if_gnt, if_rvalid, if_err;
    logic [31:0]   if_addr, if_rdata;
    logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0]   dbg_addr, dbg_wdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [DL-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    logic [31:0]   mem [0:(1<<DL)-1];

    typedef struct {
        logic        owner;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_access_arbiter #(.DEPTH_LOG2(DL)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic owner, input logic err, input logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.err   = err;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd);
        @(posedge clk);
        #1;
        if_req    = ir;
        if_addr   = ia;
        if_flush  = fl;
        dbg_req   = dr;
        dbg_we    = dw;
        dbg_addr  = da;
        dbg_wdata = dd;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && (if_rvalid || dbg_rvalid)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got if_rvalid=%b dbg_rvalid=%b expected none at %0t",
                         if_rvalid, dbg_rvalid, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_owner", {31'h0, dbg_rvalid}, {31'h0, e.owner});
                chk("rsp_both", {31'h0, if_rvalid && dbg_rvalid}, 32'h0);
                chk("rsp_err", {31'h0, e.owner ? dbg_err : if_err}, {31'h0, e.err});
                chk("rsp_data", e.owner ? dbg_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << DL); i++) mem[i] = 32'h1000_0000 | i;
        mem[2] = 32'h0050_0093;

        resetn = 1'b0;
        if_req = 1'b1; if_addr = 32'h8; if_flush = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4; dbg_wdata = 32'h0;
        #2;
        chk("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
        chk("rst_dbg_gnt", {31'h0, dbg_gnt}, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        chk("rst_dbg_rvalid", {31'h0, dbg_rvalid}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_errs", {30'h0, if_err, dbg_err}, 32'h0);
        if_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Conflict from reset: IF, DBG, IF, DBG.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
            chk("rr_if_gnt", {31'h0, if_gnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_dbg_gnt", {31'h0, dbg_gnt}, (k % 2 == 0) ? 32'h0 : 32'h1);
            chk("rr_mem_addr", {21'h0, mem_addr}, (k % 2 == 0) ? 32'h2 : 32'h1);
            if (k % 2 == 0) push(1'b0, 1'b0, 32'h0050_0093);
            else            push(1'b1, 1'b0, 32'h1000_0001);
        end
        idle();

        // IF-only read of word 2.
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("ifrd_gnt", {31'h0, if_gnt}, 32'h1);
        chk("ifrd_mem_en", {31'h0, mem_en}, 32'h1);
        chk("ifrd_mem_we", {31'h0, mem_we}, 32'h0);
        chk("ifrd_mem_addr", {21'h0, mem_addr}, 32'h2);
        push(1'b0, 1'b0, 32'h0050_0093);

        // DBG write to word 4, then IF read of the same word.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        chk("wr_dbg_gnt", {31'h0, dbg_gnt}, 32'h1);
        chk("wr_if_gnt", {31'h0, if_gnt}, 32'h0);
`ifdef IMEM_DBG_WRITE_EN
        chk("wr_mem_en", {31'h0, mem_en}, 32'h1);
        chk("wr_mem_we", {31'h0, mem_we}, 32'h1);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        push(1'b1, 1'b0, 32'h0);
`else
        chk("wr_mem_en", {31'h0, mem_en}, 32'h0);
        chk("wr_mem_we", {31'h0, mem_we}, 32'h0);
        push(1'b1, 1'b1, 32'h0);
`endif
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("raw_if_gnt", {31'h0, if_gnt}, 32'h1);
`ifdef IMEM_DBG_WRITE_EN
        push(1'b0, 1'b0, 32'hDEAD_BEEF);
`else
        push(1'b0, 1'b0, 32'h1000_0004);
`endif

        // Address faults: misaligned, out of range, DBG misaligned read.
        step(1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("mis_gnt", {31'h0, if_gnt}, 32'h1);
        chk("mis_mem_en", {31'h0, mem_en}, 32'h0);
        push(1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("oor_gnt", {31'h0, if_gnt}, 32'h1);
        chk("oor_mem_en", {31'h0, mem_en}, 32'h0);
        push(1'b0, 1'b1, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h3, 32'h0);
        chk("dmis_mem_en", {31'h0, mem_en}, 32'h0);
        push(1'b1, 1'b1, 32'h0);
        idle();

        // Flush drops the pending fetch; a fetch granted in the flush cycle survives.
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("fl_gnt0", {31'h0, if_gnt}, 32'h1);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("fl_gnt1", {31'h0, if_gnt}, 32'h1);
        chk("fl_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        push(1'b0, 1'b0, 32'h1000_0003);
        idle();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
        push(1'b1, 1'b0, 32'h1000_0001);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("fl_dbg_rvalid", {31'h0, dbg_rvalid}, 32'h1);
        idle();

        // Reset asserted between grant and response.
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rs_gnt", {31'h0, if_gnt}, 32'h1);
        #1;
        resetn = 1'b0;
        if_req = 1'b0;
        #1;
        chk("rs_gnt_low", {31'h0, if_gnt}, 32'h0);
        @(posedge clk);
        #1;
        chk("rs_rvalid_in", {31'h0, if_rvalid}, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        chk("rs_rvalid_out", {31'h0, if_rvalid}, 32'h0);
        idle();
        chk("rs_rvalid_idle", {31'h0, if_rvalid}, 32'h0);
        step(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
        chk("rs_first_if", {31'h0, if_gnt}, 32'h1);
        chk("rs_first_dbg", {31'h0, dbg_gnt}, 32'h0);
        push(1'b0, 1'b0, 32'h0050_0093);
        idle();

        // Reset asserted during the response cycle kills the rvalid at once.
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        resetn = 1'b0;
        #1;
        chk("rs2_rvalid", {31'h0, if_rvalid}, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        idle();
        idle();
        idle();

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_access_arbiter.md
# imem_access_arbiter

Shares the single-port, synchronous-read instruction memory between the pipeline fetch stage (IF) and the debug/program-loader port (DBG). It grants at most one access per cycle with round-robin fairness on conflict and issues the memory enable, write and address. It returns read data with one cycle of latency, tagged to the winning requester. It also screens misaligned and out-of-range addresses, supports an IF flush that drops an in-flight fetch, and sits between the fetch stage, the debug loader and the instruction memory array.

## Interface
- DEPTH_LOG2, 11: memory holds 2**DEPTH_LOG2 32-bit words; word index = addr[DEPTH_LOG2+1:2]
- clk  in  1  clock, all state on posedge
- resetn  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_flush  in  1  discard the fetch response due this cycle
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch data, 0 when if_rvalid=0 or error
- if_err  out  1  fetch address fault, qualified by if_rvalid
- dbg_req  in  1  debug request
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  32  debug byte address
- dbg_wdata  in  32  write data
- dbg_gnt  out  1  debug accepted this cycle (combinational)
- dbg_rvalid  out  1  debug response/ack valid
- dbg_rdata  out  32  read data, 0 for writes, errors and when dbg_rvalid=0
- dbg_err  out  1  debug fault, qualified by dbg_rvalid
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  DEPTH_LOG2  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- Arbitration state: last_gnt register (IF or DBG).
  - Only one requester: it is granted.
  - Both requesting: the one not equal to last_gnt is granted.
  - last_gnt updates on every grant.
- Fault check on the granted request:
  - misaligned: addr[1:0] != 0
  - out of range: addr[31:2] >= 2**DEPTH_LOG2
  - A faulting request is still granted. mem_en stays 0 and the response carries err=1 and rdata=0.
- Legal grant: mem_en=1, mem_addr=addr[DEPTH_LOG2+1:2].
  - IF grant: mem_we=0.
  - DBG grant: mem_we=dbg_we, mem_wdata=dbg_wdata.
- Response pipeline: one register stage holding {valid, owner, err, is_write}. The owner's rvalid asserts the next cycle.
  - rdata = mem_rdata for a legal read, otherwise 0.
  - A DBG write acks with dbg_rvalid=1, dbg_rdata=0, dbg_err=0.
- Flush: if_flush=1 forces if_rvalid=0 and if_err=0 in that cycle. It does not affect DBG responses or a same-cycle new IF grant.
- Non-granted requesters must hold req and address until granted. Outputs do not depend on request stability.

## Timing
- Grant and memory controls: combinational, same cycle as the request.
- Response latency: exactly 1 cycle after grant. Full throughput of one access per cycle, with back-to-back grants allowed.
- Conflict sequence with both held high from reset: IF, DBG, IF, DBG, ...
- Reset values: last_gnt=DBG (IF wins the first conflict), response valid=0, all rvalid/err=0, all rdata=0, all gnt/mem_en/mem_we=0 while resetn=0.
- Reset asserted mid-operation: the in-flight response is dropped asynchronously and no rvalid pulse appears after reset release.
- Read-after-write on the same word by DBG then IF in consecutive cycles: the IF read returns the new data. This is a memory-array property and is verified through the bench model.

## Configuration
- IMEM_DBG_WRITE_EN
  - Defined: DBG writes proceed as described.
  - Undefined: mem_we is tied to 0. A DBG request with dbg_we=1 is granted but performs no memory access, and acks with dbg_err=1, dbg_rdata=0. DBG reads are unaffected.

## Test plan
- Reset, then IF-only read at 0x00000008 with memory word 2 = 0x00500093 -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=0x00500093, if_err=0.
- if_req and dbg_req (read) both held for 4 cycles after reset -> grants IF, DBG, IF, DBG; each rvalid one cycle after its grant with the correct owner.
- DBG write 0xDEADBEEF to 0x00000010, then IF read of 0x10 the next cycle -> dbg_rvalid=1 with dbg_rdata=0; IF read returns 0xDEADBEEF. Without the macro: dbg_err=1, and IF reads the old value.
- IF read at 0x00000006, then at 0x00002000 with DEPTH_LOG2=11 -> mem_en=0 for both; if_rvalid=1, if_err=1, if_rdata=0 each time.
- IF grant, then if_flush=1 on the following cycle -> if_rvalid=0. A new IF grant in the flush cycle responds normally the cycle after.
- IF grant, then resetn pulled low before the response cycle -> if_rvalid stays 0 through and after reset release; the first conflict after reset goes to IF.
